// File: rtl/paddle_ctrl.sv
// Frame-paced paddle position controller: each debounced press starts a glide of
// MOVE_FRAMES frame ticks at STEP pixels per tick, clamped to 0..Y_MAX.
module paddle_ctrl #(
   parameter int SCREEN_H    = 480,
   parameter int PADDLE_H    = 64,
   parameter int STEP        = 4,
   parameter int MOVE_FRAMES = 8,
   parameter int Y_W         = 10
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           up_press,
   input  logic           down_press,
   input  logic           frame_tick,
   input  logic           recenter,
   output logic [Y_W-1:0] paddle_y,
   output logic           moving,
   output logic           dir_down
);

   localparam int unsigned    Y_MAX_I = SCREEN_H - PADDLE_H;
   localparam int unsigned    FW      = $clog2(MOVE_FRAMES + 1);
   localparam logic [Y_W-1:0] Y_MAX   = Y_W'(Y_MAX_I);
   localparam logic [Y_W-1:0] Y_INIT  = Y_W'(Y_MAX_I / 2);
   localparam logic [Y_W-1:0] STEP_Y  = Y_W'(STEP);
   // Highest position from which a full downward step still fits below Y_MAX.
   localparam logic [Y_W-1:0] Y_HI    = Y_W'(Y_MAX_I - STEP);
   localparam logic [FW-1:0]  FR_LOAD = FW'(MOVE_FRAMES);

   typedef enum logic {IDLE, GLIDE} state_t;

   state_t          state, state_nxt;
   logic [FW-1:0]   frames_left, fl_nxt;
   logic [Y_W-1:0]  y_nxt;
   logic            dir_nxt;
   logic            up_only, dn_only, press, press_at_bound;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         frames_left <= '0;
         paddle_y    <= Y_INIT;
         dir_down    <= 1'b0;
      end else begin
         state       <= state_nxt;
         frames_left <= fl_nxt;
         paddle_y    <= y_nxt;
         dir_down    <= dir_nxt;
      end
   end

   assign moving = (state == GLIDE);

   always_comb begin
      state_nxt      = state;
      fl_nxt         = frames_left;
      y_nxt          = paddle_y;
      dir_nxt        = dir_down;
      up_only        = up_press & ~down_press;
      dn_only        = down_press & ~up_press;
      press          = up_only | dn_only;
      press_at_bound = up_only ? (paddle_y == '0) : (paddle_y == Y_MAX);

      if (recenter) begin
         state_nxt = IDLE;
         fl_nxt    = '0;
         y_nxt     = Y_INIT;
      end else if (press) begin
         // A press toward a bound already reached ends (or never starts) a glide.
         if (press_at_bound) begin
            state_nxt = IDLE;
            fl_nxt    = '0;
         end else begin
            state_nxt = GLIDE;
            fl_nxt    = FR_LOAD;
            dir_nxt   = dn_only;
         end
      end else if (frame_tick && (state == GLIDE)) begin
         if (dir_down)
            y_nxt = (paddle_y > Y_HI) ? Y_MAX : paddle_y + STEP_Y;
         else
            y_nxt = (paddle_y < STEP_Y) ? '0 : paddle_y - STEP_Y;
         fl_nxt = frames_left - FW'(1);
         if ((fl_nxt == '0) || (y_nxt == (dir_down ? Y_MAX : '0)))
            state_nxt = IDLE;
      end
   end

endmodule
